// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and default parameters for the fetch sequencer
//
// Purpose: state enum for the fetch control FSM and the default values of the
//          fetch_sequencer parameters.
// Ports:   none (package).

package fetch_seq_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } fsState_t;

  localparam int DEF_ADDR_WIDTH   = 24;
  localparam int DEF_INIT_CYCLES  = 2;
  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_CNT_WIDTH    = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: profiling counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (q -> 0)
//   clr  in   synchronous clear, wins over inc
//   inc  in   increment request
//   q    out  counter value [width-1:0]

module sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch control FSM with profiling counters
//
// Purpose: drives PC-update / fetch-buffer reset and enable strobes, holds them
//          in reset for a start-up window, sequences branch redirects as a timed
//          flush, freezes on stall/halt and counts fetch, stall and flush events.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stallReq                 downstream hazard, freeze fetch
//   branchTaken/Target       taken-branch pulse and its target address
//   haltReq, resume          enter / leave HALT
//   counterClear             synchronous clear of all counters
//   pcRst, bufRst            resets to PC register and fetch buffer
//   pcEn, bufEn              enables to PC register and fetch buffer
//   branchFlag, branchAddr   PC loads branchAddr this cycle; latched target
//   halted                   high while in HALT
//   fetchCount, stallCount, flushCount   saturating performance counters

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallReq,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  haltReq,
  input  logic                  resume,
  input  logic                  counterClear,
  output logic                  pcRst,
  output logic                  bufRst,
  output logic                  pcEn,
  output logic                  bufEn,
  output logic                  branchFlag,
  output logic [ADDR_WIDTH-1:0] branchAddr,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetchCount,
  output logic [CNT_WIDTH-1:0]  stallCount,
  output logic [CNT_WIDTH-1:0]  flushCount
);

  // One phase counter serves both the INIT window and the FLUSH window;
  // it only needs to reach the larger window length minus one.
  localparam int PHASE_MAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  fsState_t           state, stateNext;
  logic [PHASE_W-1:0] phase, phaseNext;
  logic               latchBranch;
  logic               initDone, flushDone;

  assign initDone  = (phase == PHASE_W'(INIT_CYCLES - 1));
  assign flushDone = (phase == PHASE_W'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      phase      <= '0;
      branchAddr <= '0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
      if (latchBranch) begin
        branchAddr <= branchTarget;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    phaseNext   = phase;
    latchBranch = 1'b0;
    pcRst       = 1'b0;
    bufRst      = 1'b0;
    pcEn        = 1'b0;
    bufEn       = 1'b0;
    branchFlag  = 1'b0;
    halted      = 1'b0;

    case (state)
      INIT: begin
        pcRst  = 1'b1;
        bufRst = 1'b1;
        if (initDone) begin
          stateNext = RUN;
          phaseNext = '0;
        end else begin
          phaseNext = phase + 1'b1;
        end
      end

      RUN, STALL: begin
        pcEn  = (state == RUN);
        bufEn = (state == RUN);
        // Branch beats halt beats stall; a halt arriving with a branch is dropped.
        if (branchTaken) begin
          latchBranch = 1'b1;
          stateNext   = FLUSH;
          phaseNext   = '0;
        end else if (haltReq) begin
          stateNext = HALT;
        end else if (stallReq) begin
          stateNext = STALL;
        end else begin
          stateNext = RUN;
        end
      end

      FLUSH: begin
        pcEn       = 1'b1;
        bufRst     = 1'b1;
        // Phase 0 is the first cycle after any latch, so a re-latch re-pulses the flag.
        branchFlag = (phase == '0);
        if (branchTaken) begin
          latchBranch = 1'b1;
          phaseNext   = '0;
        end else if (flushDone) begin
          stateNext = RUN;
          phaseNext = '0;
        end else begin
          phaseNext = phase + 1'b1;
        end
      end

      HALT: begin
        halted = 1'b1;
        if (resume) begin
          stateNext = RUN;
        end
      end

      default: begin
        stateNext = INIT;
        phaseNext = '0;
      end
    endcase
  end

  sat_counter #(.width(CNT_WIDTH)) uFetchCnt (
    .clk (clk),
    .rst (rst),
    .clr (counterClear),
    .inc (state == RUN),
    .q   (fetchCount)
  );

  sat_counter #(.width(CNT_WIDTH)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .clr (counterClear),
    .inc (state == STALL),
    .q   (stallCount)
  );

  sat_counter #(.width(CNT_WIDTH)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .clr (counterClear),
    .inc (latchBranch),
    .q   (flushCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a behavioural model

module tb_fetch_sequencer;

  localparam int AW = 24;
  localparam int IC = 2;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          stallReq, branchTaken, haltReq, resume, counterClear;
  logic [AW-1:0] branchTarget;
  logic          pcRst, bufRst, pcEn, bufEn, branchFlag, halted;
  logic [AW-1:0] branchAddr;
  logic [CW-1:0] fetchCount, stallCount, flushCount;

  fetch_sequencer #(
    .ADDR_WIDTH  (AW),
    .INIT_CYCLES (IC),
    .FLUSH_CYCLES(FC),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallReq    (stallReq),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .haltReq     (haltReq),
    .resume      (resume),
    .counterClear(counterClear),
    .pcRst       (pcRst),
    .bufRst      (bufRst),
    .pcEn        (pcEn),
    .bufEn       (bufEn),
    .branchFlag  (branchFlag),
    .branchAddr  (branchAddr),
    .halted      (halted),
    .fetchCount  (fetchCount),
    .stallCount  (stallCount),
    .flushCount  (flushCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a mode name, cycles remaining in the timed windows,
  // and plain integer counters clipped at the counter maximum.
  localparam int M_INIT = 0, M_RUN = 1, M_STALL = 2, M_FLUSH = 3, M_HALT = 4;
  int            mode;
  int            remain;
  bit            firstFlush;
  logic [AW-1:0] expAddr;
  int            nFetch, nStall, nFlush;

  function automatic int bump(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic modelReset();
    mode = M_INIT; remain = IC; firstFlush = 0;
    expAddr = '0; nFetch = 0; nStall = 0; nFlush = 0;
  endtask

  task automatic modelStep();
    bit latch = 0;
    bit wasRun = (mode == M_RUN);
    bit wasStall = (mode == M_STALL);
    case (mode)
      M_INIT: begin
        remain--;
        if (remain == 0) mode = M_RUN;
      end
      M_RUN, M_STALL: begin
        if (branchTaken) latch = 1;
        else if (haltReq) mode = M_HALT;
        else if (stallReq) mode = M_STALL;
        else mode = M_RUN;
      end
      M_FLUSH: begin
        if (branchTaken) latch = 1;
        else begin
          remain--;
          firstFlush = 0;
          if (remain == 0) mode = M_RUN;
        end
      end
      default: if (resume) mode = M_RUN;
    endcase
    if (latch) begin
      expAddr = branchTarget; mode = M_FLUSH; remain = FC; firstFlush = 1;
    end
    if (counterClear) begin
      nFetch = 0; nStall = 0; nFlush = 0;
    end else begin
      if (wasRun)   nFetch = bump(nFetch);
      if (wasStall) nStall = bump(nStall);
      if (latch)    nFlush = bump(nFlush);
    end
  endtask

  task automatic checkOutputs();
    checkEq("pcRst",      pcRst,      mode == M_INIT);
    checkEq("bufRst",     bufRst,     mode == M_INIT || mode == M_FLUSH);
    checkEq("pcEn",       pcEn,       mode == M_RUN || mode == M_FLUSH);
    checkEq("bufEn",      bufEn,      mode == M_RUN);
    checkEq("branchFlag", branchFlag, mode == M_FLUSH && firstFlush);
    checkEq("halted",     halted,     mode == M_HALT);
    checkEq("branchAddr", branchAddr, expAddr);
    checkEq("fetchCount", fetchCount, nFetch);
    checkEq("stallCount", stallCount, nStall);
    checkEq("flushCount", flushCount, nFlush);
  endtask

  task automatic idle();
    stallReq = 0; branchTaken = 0; haltReq = 0; resume = 0; counterClear = 0;
    branchTarget = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic branch(input logic [AW-1:0] tgt);
    branchTaken = 1; branchTarget = tgt;
    tick();
    branchTaken = 0;
  endtask

  // Reset asserted between clock edges; outputs must respond without a clock.
  task automatic asyncReset();
    #2;
    rst = 1;
    idle();
    #1;
    modelReset();
    checkOutputs();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutputs();
    @(negedge clk);
    rst = 0;

    // Start-up window, then first RUN cycle.
    ticks(3);
    checkEq("fetchCount after first RUN", fetchCount, 1);

    // Redirect from RUN.
    branch(24'h000140);
    checkEq("redirect branchAddr", branchAddr, 24'h000140);
    ticks(3);
    checkEq("flushCount single", flushCount, 1);

    // Four-cycle stall, then branch out of a stall.
    stallReq = 1;
    ticks(4);
    stallReq = 0;
    tick();
    stallReq = 1;
    ticks(2);
    branch(24'h00abcd);
    stallReq = 0;
    ticks(3);

    // Halt wins over stall; everything but resume is ignored while halted.
    haltReq = 1; stallReq = 1;
    tick();
    haltReq = 0;
    branchTaken = 1; branchTarget = 24'h0000ee;
    ticks(2);
    idle();
    resume = 1;
    tick();
    resume = 0;
    tick();

    // Branch beats halt and stall arriving together.
    branchTaken = 1; haltReq = 1; stallReq = 1; branchTarget = 24'h000777;
    tick();
    idle();
    ticks(2);

    // Back-to-back redirects re-latch the target and re-pulse branchFlag.
    branch(24'h000010);
    branch(24'h000020);
    checkEq("re-latch branchAddr", branchAddr, 24'h000020);
    ticks(3);

    // Saturation of the narrow counters, then clear coinciding with increment.
    ticks(20);
    checkEq("fetchCount saturated", fetchCount, CNT_MAX);
    counterClear = 1;
    tick();
    counterClear = 0;
    checkEq("fetchCount cleared", fetchCount, 0);
    tick();

    // Asynchronous reset in the middle of a stall.
    stallReq = 1;
    ticks(3);
    asyncReset();
    ticks(4);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      stallReq     = ($urandom_range(0, 2) == 0);
      branchTaken  = ($urandom_range(0, 7) == 0);
      haltReq      = ($urandom_range(0, 15) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      counterClear = ($urandom_range(0, 40) == 0);
      branchTarget = AW'($urandom);
      if ($urandom_range(0, 199) == 0) asyncReset();
      else tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
